sd_host_cmd: RTL and testbench
==============================

# sd_host_cmd

SD-bus host command engine: the initiator side of the SD CMD line that the fake-card controller answers. It generates `sdclk` from the system clock, serialises a 48-bit command frame with CRC7 onto `sdcmd`, then captures and checks the card's R1/R3/R6/R7 (48-bit) or R2 (136-bit) response. It is the building block for a bench/host that drives the fake SD card from the same FPGA, and for a card-side loopback test.

## Interface
- `CLK_DIV`, 62: `clk` cycles per `sdclk` half-period (50 MHz / 124 ≈ 403 kHz init clock); legal range ≥ 2.
- `TIMEOUT`, 64: maximum `sdclk` rising edges waited for the response start bit (Ncr).

- `clk`  in  1  system clock (50 MHz nominal); the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `cmd_index`  in  6  command index.
- `cmd_arg`  in  32  command argument.
- `resp_type`  in  2  0 = none, 1 = R48 with CRC, 2 = R48 without CRC check (R3), 3 = R136.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of transaction.
- `resp_timeout`  out  1  valid with `done`; held until next accepted `start`.
- `resp_crc_err`  out  1  valid with `done`; held until next accepted `start`.
- `resp`  out  136  raw response bits, right-aligned (R48 in [47:0], upper bits 0).
- `sdclk`  out  1  SD clock.
- `sdcmd_o`  out  1  CMD line drive value.
- `sdcmd_oe`  out  1  CMD line output enable (top-level builds the tri-state).
- `sdcmd_i`  in  1  CMD line sampled value.

## Operation
- Divider: counter 0..CLK_DIV-1; on wrap, `sdclk` toggles. A toggle 1→0 is a fall tick, 0→1 a rise tick. `sdclk` runs continuously out of reset.
- Host drives `sdcmd_o`/`sdcmd_oe` only on fall ticks; samples `sdcmd_i` only on rise ticks.
- Frame (MSB first): `0`, `1`, `cmd_index[5:0]`, `cmd_arg[31:0]`, `crc7[6:0]`, `1`. CRC7 polynomial x^7+x^3+1, init 0, over the first 40 bits.
- Inputs latched when `start` is accepted; later changes ignored.
- States:
  - IDLE: `sdcmd_oe`=0, `busy`=0. `start` → SEND.
  - SEND: 48 fall ticks drive bits 47..0. On the fall tick after bit 0, `sdcmd_oe`→0. If `resp_type`=0 → GAP; else → WAIT.
  - WAIT: on each rise tick, if `sdcmd_i`=0 → RECV (start bit counted as bit 1). After TIMEOUT rise ticks with no 0, set `resp_timeout` → GAP.
  - RECV: shift `sdcmd_i` into `resp` LSB on each rise tick until 48 or 136 bits are collected → GAP.
  - GAP: 8 rise ticks (Ncc) with the line released, then pulse `done` and go to IDLE.
- CRC check:
  - R48: CRC7 over `resp[47:8]` must equal `resp[7:1]`.
  - R136: CRC7 over `resp[127:8]` must equal `resp[7:1]`.
  - Type 2 skips the CRC compare.
  - For types 1–3, `resp[0]`≠1 also sets `resp_crc_err`.
- Accepted `start` clears `resp`, `resp_timeout` and `resp_crc_err`. `start` while `busy` is ignored.

## Timing
- Reset values: `sdclk`=0, `sdcmd_o`=1, `sdcmd_oe`=0, `busy`=0, `done`=0, `resp_timeout`=0, `resp_crc_err`=0, `resp`=0; divider=0; state=IDLE.
- Reset asserted mid-transaction aborts immediately to the reset values. No `done` is produced.
- `busy` rises 1 `clk` after `start`. First frame bit appears at the first fall tick after acceptance.
- Command phase: 48 `sdclk` periods. Type-0 total: 48 + 8 periods + ≤1 period of alignment.
- `resp` and flags are stable on the `done` cycle. The CRC result is computed serially during RECV, so no extra latency.
- `done` and `busy` deassertion occur in the same `clk` cycle.

## Test plan
- CMD0, arg 0x00000000, type 0 → `sdcmd` carries 0x400000000095. `done` after 56 sdclk periods (±1). No flags set.
- CMD8, arg 0x000001AA, type 1; model answers after 2 sdclk with a correct R7 echo → frame 0x48000001AA87. `resp[47:0]` equals the model frame. `resp_crc_err`=0.
- Same as above, with the model flipping one argument bit → `resp_crc_err`=1, `resp_timeout`=0.
- CMD55, arg 0, type 1, no card response → frame 0x770000000065. `resp_timeout`=1 after 64 rise ticks. `resp`=0.
- ACMD41 with a type-2 response whose CRC field is 0x7F → `resp_crc_err`=0.
- CMD2 with a 136-bit model CID and valid CRC → `resp[135:0]` matches the model.
  - `start` pulsed during RECV is ignored.
  - `rst_n` low mid-RECV: all outputs return to their reset values, then a new CMD0 succeeds.

Source files
------------

// File: rtl/sd_host_cmd.sv
`default_nettype none
// ============================================================================
// Module   : sd_host_cmd
// Purpose  : SD CMD-line host engine. Divides clk into sdclk, sends a 48-bit
//            command frame with CRC7, then captures and checks the response.
// Revision : 1.0  initial release
// ============================================================================
module sd_host_cmd #(
    parameter int CLK_DIV = 62,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         busy,
    output logic         done,
    output logic         resp_timeout,
    output logic         resp_crc_err,
    output logic [135:0] resp,
    output logic         sdclk,
    output logic         sdcmd_o,
    output logic         sdcmd_oe,
    input  logic         sdcmd_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_GAP  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic               sdclk_q;
    logic [47:0]        frame_q, frame_d;
    logic [1:0]         type_q, type_d;
    logic [7:0]         bcnt_q, bcnt_d;
    logic [TO_W-1:0]    tcnt_q, tcnt_d;
    logic [6:0]         crc_q, crc_d;
    logic [135:0]       resp_q, resp_d;
    logic               to_q, to_d;
    logic               crcerr_q, crcerr_d;
    logic               done_q, done_d;
    logic               cmd_o_q, cmd_o_d;
    logic               cmd_oe_q, cmd_oe_d;

    logic               wrap, fall_tick, rise_tick;
    logic [135:0]       resp_shift;
    logic               crc_en;
    logic [7:0]         last_bit;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] msg;
        logic [6:0]  crc;
        msg = {2'b01, idx, arg};
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            crc = crc7_next(crc, msg[i]);
        end
        return {msg, crc, 1'b1};
    endfunction

    // Ticks are flagged in the cycle before sdclk actually toggles, so the
    // CMD output changes on the same clk edge that drops sdclk.
    assign wrap      = (div_q == DIV_W'(CLK_DIV - 1));
    assign fall_tick = wrap & sdclk_q;
    assign rise_tick = wrap & ~sdclk_q;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        type_d     = type_q;
        bcnt_d     = bcnt_q;
        tcnt_d     = tcnt_q;
        crc_d      = crc_q;
        resp_d     = resp_q;
        to_d       = to_q;
        crcerr_d   = crcerr_q;
        done_d     = 1'b0;
        cmd_o_d    = cmd_o_q;
        cmd_oe_d   = cmd_oe_q;
        resp_shift = {resp_q[134:0], sdcmd_i};
        last_bit   = (type_q == 2'd3) ? 8'd135 : 8'd47;
        crc_en     = (type_q == 2'd3) ? ((bcnt_q >= 8'd8) && (bcnt_q < 8'd128))
                                      : (bcnt_q < 8'd40);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SEND;
                    frame_d  = build_frame(cmd_index, cmd_arg);
                    type_d   = resp_type;
                    bcnt_d   = 8'd0;
                    resp_d   = '0;
                    to_d     = 1'b0;
                    crcerr_d = 1'b0;
                end
            end
            S_SEND: begin
                if (fall_tick) begin
                    if (bcnt_q == 8'd48) begin
                        cmd_oe_d = 1'b0;
                        cmd_o_d  = 1'b1;
                        bcnt_d   = 8'd0;
                        tcnt_d   = '0;
                        state_d  = (type_q == 2'd0) ? S_GAP : S_WAIT;
                    end else begin
                        cmd_oe_d = 1'b1;
                        cmd_o_d  = frame_q[47];
                        frame_d  = {frame_q[46:0], 1'b0};
                        bcnt_d   = bcnt_q + 8'd1;
                    end
                end
            end
            S_WAIT: begin
                if (rise_tick) begin
                    if (!sdcmd_i) begin
                        state_d = S_RECV;
                        resp_d  = resp_shift;
                        bcnt_d  = 8'd1;
                        crc_d   = '0;
                    end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                        to_d    = 1'b1;
                        bcnt_d  = 8'd0;
                        state_d = S_GAP;
                    end else begin
                        tcnt_d  = tcnt_q + 1'b1;
                    end
                end
            end
            S_RECV: begin
                // bcnt_q counts bits already held; the incoming one is bit bcnt_q+1.
                if (rise_tick) begin
                    resp_d = resp_shift;
                    bcnt_d = bcnt_q + 8'd1;
                    if (crc_en) begin
                        crc_d = crc7_next(crc_q, sdcmd_i);
                    end
                    if (bcnt_q == last_bit) begin
                        crcerr_d = ~resp_shift[0] |
                                   ((type_q != 2'd2) && (crc_q != resp_shift[7:1]));
                        bcnt_d   = 8'd0;
                        state_d  = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (rise_tick) begin
                    if (bcnt_q == 8'd7) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bcnt_d  = bcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            sdclk_q  <= 1'b0;
            frame_q  <= '0;
            type_q   <= 2'd0;
            bcnt_q   <= 8'd0;
            tcnt_q   <= '0;
            crc_q    <= '0;
            resp_q   <= '0;
            to_q     <= 1'b0;
            crcerr_q <= 1'b0;
            done_q   <= 1'b0;
            cmd_o_q  <= 1'b1;
            cmd_oe_q <= 1'b0;
        end else begin
            div_q    <= wrap ? '0 : div_q + 1'b1;
            sdclk_q  <= sdclk_q ^ wrap;
            state_q  <= state_d;
            frame_q  <= frame_d;
            type_q   <= type_d;
            bcnt_q   <= bcnt_d;
            tcnt_q   <= tcnt_d;
            crc_q    <= crc_d;
            resp_q   <= resp_d;
            to_q     <= to_d;
            crcerr_q <= crcerr_d;
            done_q   <= done_d;
            cmd_o_q  <= cmd_o_d;
            cmd_oe_q <= cmd_oe_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign resp_timeout = to_q;
    assign resp_crc_err = crcerr_q;
    assign resp         = resp_q;
    assign sdclk        = sdclk_q;
    assign sdcmd_o      = cmd_o_q;
    assign sdcmd_oe     = cmd_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_host_cmd.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_host_cmd
// Purpose  : Directed bench for sd_host_cmd with a simple card responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_host_cmd;

    localparam int CLK_DIV = 3;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         busy, done, resp_timeout, resp_crc_err;
    logic [135:0] resp;
    logic         sdclk, sdcmd_o, sdcmd_oe;
    logic         sdcmd_i;
    logic         card_oe  = 1'b0;
    logic         card_bit = 1'b1;

    always #5 clk = ~clk;

    // Open-drain style bus with pull-up: host, then card, else idle high.
    assign sdcmd_i = sdcmd_oe ? sdcmd_o : (card_oe ? card_bit : 1'b1);

    sd_host_cmd #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .resp_type(resp_type), .busy(busy), .done(done),
        .resp_timeout(resp_timeout), .resp_crc_err(resp_crc_err), .resp(resp),
        .sdclk(sdclk), .sdcmd_o(sdcmd_o), .sdcmd_oe(sdcmd_oe), .sdcmd_i(sdcmd_i)
    );

    int           n_checks = 0;
    int           n_err    = 0;
    logic [47:0]  cap;
    int           cap_n;
    int           rises;
    bit           got_done, aborted, stalled, busy_after;
    logic [135:0] d_resp;
    logic         d_to, d_crc, d_busy, d_oe;
    logic [135:0] rsp_bits;
    int           rsp_len   = 0;
    int           rsp_delay = 2;
    int           ignore_at = -1;
    int           abort_at  = -1;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_fall();
        logic prev;
        prev = sdclk;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (prev && !sdclk) return;
            prev = sdclk;
        end
        stalled = 1'b1;
    endtask

    task automatic card_thread();
        int k;
        k = 0;
        while (cap_n < 48 && k < 3000 && !got_done) begin
            @(negedge clk);
            k++;
        end
        if (rsp_len > 0 && cap_n == 48) begin
            repeat (rsp_delay) wait_fall();
            for (int i = 0; i < rsp_len && !stalled; i++) begin
                wait_fall();
                card_oe  = 1'b1;
                card_bit = rsp_bits[rsp_len-1-i];
                if (i == ignore_at) begin
                    @(negedge clk); start = 1'b1;
                    @(negedge clk); start = 1'b0;
                end
                if (i == abort_at) begin
                    @(negedge clk);
                    rst_n   = 1'b0;
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) wait_fall();
            card_oe  = 1'b0;
            card_bit = 1'b1;
        end
    endtask

    task automatic done_thread();
        logic prev;
        prev = sdclk;
        for (int k = 0; k < 5000 && !got_done && !aborted; k++) begin
            @(negedge clk);
            if (sdclk && !prev) begin
                rises++;
                if (sdcmd_oe) begin
                    cap = {cap[46:0], sdcmd_o};
                    cap_n++;
                end
            end
            prev = sdclk;
            if (done) begin
                got_done = 1'b1;
                d_resp   = resp;
                d_to     = resp_timeout;
                d_crc    = resp_crc_err;
                d_busy   = busy;
                d_oe     = sdcmd_oe;
            end
        end
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        cap = '0; cap_n = 0; rises = 0;
        got_done = 1'b0; aborted = 1'b0; stalled = 1'b0;
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; resp_type = rt; start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        busy_after = busy;
        // Inputs must have been latched at acceptance.
        cmd_index  = ~idx; cmd_arg = ~arg; resp_type = ~rt;
        fork
            card_thread();
            done_thread();
        join
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_type = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_sdclk",  sdclk,        1'b0);
        check_eq("rst_cmd_o",  sdcmd_o,      1'b1);
        check_eq("rst_oe",     sdcmd_oe,     1'b0);
        check_eq("rst_busy",   busy,         1'b0);
        check_eq("rst_done",   done,         1'b0);
        check_eq("rst_flags",  {resp_timeout, resp_crc_err}, 2'b00);
        check_eq("rst_resp",   resp,         136'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // CMD0, no response
        rsp_len = 0;
        do_cmd(6'd0, 32'h0, 2'd0);
        check_eq("cmd0_busy_rise", busy_after, 1'b1);
        check_eq("cmd0_frame",     cap, 48'h400000000095);
        check_eq("cmd0_done",      got_done, 1'b1);
        check_eq("cmd0_periods",   (rises >= 56 && rises <= 57), 1'b1);
        check_eq("cmd0_flags",     {d_to, d_crc}, 2'b00);
        check_eq("cmd0_busy_done", d_busy, 1'b0);
        check_eq("cmd0_resp",      d_resp, 136'h0);

        // CMD8 with correct R7 echo
        rsp_len = 48; rsp_bits = 136'h08000001AA13;
        do_cmd(6'd8, 32'h000001AA, 2'd1);
        check_eq("cmd8_frame", cap, 48'h48000001AA87);
        check_eq("cmd8_done",  got_done, 1'b1);
        check_eq("cmd8_resp",  d_resp, 136'h08000001AA13);
        check_eq("cmd8_flags", {d_to, d_crc}, 2'b00);
        check_eq("cmd8_oe",    d_oe, 1'b0);

        // CMD8 with one argument bit flipped by the card
        rsp_bits = 136'h08000001AB13;
        do_cmd(6'd8, 32'h000001AA, 2'd1);
        check_eq("cmd8bad_done",  got_done, 1'b1);
        check_eq("cmd8bad_resp",  d_resp, 136'h08000001AB13);
        check_eq("cmd8bad_flags", {d_to, d_crc}, 2'b01);

        // CMD55 with no card answer
        rsp_len = 0;
        do_cmd(6'd55, 32'h0, 2'd1);
        check_eq("cmd55_frame",   cap, 48'h770000000065);
        check_eq("cmd55_done",    got_done, 1'b1);
        check_eq("cmd55_flags",   {d_to, d_crc}, 2'b10);
        check_eq("cmd55_resp",    d_resp, 136'h0);
        check_eq("cmd55_periods", (rises >= 120 && rises <= 121), 1'b1);

        // ACMD41, R3 response with all-ones CRC field
        rsp_len = 48; rsp_bits = 136'h3F80FF8000FF;
        do_cmd(6'd41, 32'h40FF8000, 2'd2);
        check_eq("acmd41_done",  got_done, 1'b1);
        check_eq("acmd41_resp",  d_resp, 136'h3F80FF8000FF);
        check_eq("acmd41_flags", {d_to, d_crc}, 2'b00);

        // CMD2, R2 CID with a stray start pulse mid-response
        rsp_len = 136; ignore_at = 60;
        rsp_bits = {8'h3F, 120'h80_0000_0000_0000_0000_0000_0200_0101, 8'h81};
        do_cmd(6'd2, 32'h0, 2'd3);
        ignore_at = -1;
        check_eq("cmd2_frame", cap, 48'h42000000004D);
        check_eq("cmd2_done",  got_done, 1'b1);
        check_eq("cmd2_resp",  d_resp, {8'h3F, 120'h80_0000_0000_0000_0000_0000_0200_0101, 8'h81});
        check_eq("cmd2_flags", {d_to, d_crc}, 2'b00);
        repeat (20) @(negedge clk);
        check_eq("cmd2_idle_after", busy, 1'b0);

        // Reset in the middle of an R2 response
        abort_at = 50;
        do_cmd(6'd2, 32'h0, 2'd3);
        abort_at = -1;
        @(negedge clk);
        check_eq("abort_seen",   aborted, 1'b1);
        check_eq("abort_sdclk",  sdclk, 1'b0);
        check_eq("abort_cmd",    {sdcmd_o, sdcmd_oe}, 2'b10);
        check_eq("abort_ctl",    {busy, done, resp_timeout, resp_crc_err}, 4'b0000);
        check_eq("abort_resp",   resp, 136'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check_eq("abort_no_done", seen, 1'b0);

        // Fresh CMD0 after the abort
        rsp_len = 0;
        do_cmd(6'd0, 32'h0, 2'd0);
        check_eq("cmd0b_frame", cap, 48'h400000000095);
        check_eq("cmd0b_done",  got_done, 1'b1);
        check_eq("cmd0b_flags", {d_to, d_crc}, 2'b00);

        check_eq("no_sdclk_stall", stalled, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
